fetch_controller: RTL and testbench

Sequencing controller for the RV32I fetch stage. It drives the program counter's next-PC select and update enable, runs the instruction-memory request/response handshake, and applies load-use stalls and taken-branch/jump redirects. It also issues the IF/ID and ID/EX flushes and keeps saturating redirect and stall counters. It sits between the PC register and instruction memory on one side and the hazard unit and execute stage on the other.

---
 rtl/fetch_controller.sv | 165 ++++++++++++++++
 tb/tb_fetch_controller.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_controller.sv
// RV32I fetch sequencer: next-PC select, imem handshake, load-use stalls,
// branch/jump redirects with stale-response draining, and saturating counters.
module fetch_controller #(
   parameter int WIDTH     = 32,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   output logic                 imem_req,
   input  logic                 imem_ready,
   input  logic                 load_use_hazard,
   input  logic                 branch_taken_ex,
   input  logic                 jalr_ex,
   input  logic                 halt,
   output logic [1:0]           PCSrc,
   output logic                 pc_en,
   output logic                 fetch_valid,
   output logic                 stall_if_id,
   output logic                 flush_if_id,
   output logic                 flush_id_ex,
   output logic                 halted,
   output logic [CNT_WIDTH-1:0] redirect_count,
   output logic [CNT_WIDTH-1:0] stall_count
);

   if (WIDTH != 32) begin : g_width_chk
      $error("fetch_controller: WIDTH must be 32 for RV32I");
   end

   typedef enum logic [2:0] {
      ST_RESET,
      ST_FETCH,
      ST_WAIT,
      ST_DRAIN,
      ST_HALTED
   } state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   state_t               state_q, state_d;
   logic [CNT_WIDTH-1:0] redirect_count_q, redirect_count_d;
   logic [CNT_WIDTH-1:0] stall_count_q, stall_count_d;
   logic                 redirect;
   logic                 redir_hit;
   logic                 active;

   always_comb begin
      state_d     = state_q;
      imem_req    = 1'b0;
      PCSrc       = 2'b00;
      pc_en       = 1'b0;
      fetch_valid = 1'b0;
      stall_if_id = 1'b0;
      flush_if_id = 1'b0;
      flush_id_ex = 1'b0;
      halted      = 1'b0;
      redir_hit   = 1'b0;
      active      = 1'b0;
      redirect    = jalr_ex | branch_taken_ex;

      unique case (state_q)
         ST_RESET: state_d = ST_FETCH;
         ST_FETCH: begin
            active = 1'b1;
            if (redirect) begin
               redir_hit = 1'b1;
               imem_req  = 1'b1;
            end else if (halt) begin
               state_d = ST_HALTED;
            end else if (load_use_hazard) begin
               stall_if_id = 1'b1;
               flush_id_ex = 1'b1;
            end else if (imem_ready) begin
               imem_req    = 1'b1;
               fetch_valid = 1'b1;
               pc_en       = 1'b1;
            end else begin
               imem_req = 1'b1;
               state_d  = ST_WAIT;
            end
         end
         ST_WAIT: begin
            active = 1'b1;
            if (redirect) begin
               redir_hit = 1'b1;
               imem_req  = 1'b1;
               // an unanswered request leaves a stale response to drain
               state_d   = imem_ready ? ST_FETCH : ST_DRAIN;
            end else if (halt) begin
               state_d = ST_HALTED;
            end else if (load_use_hazard) begin
               stall_if_id = 1'b1;
               flush_id_ex = 1'b1;
            end else if (imem_ready) begin
               imem_req    = 1'b1;
               fetch_valid = 1'b1;
               pc_en       = 1'b1;
               state_d     = ST_FETCH;
            end else begin
               imem_req = 1'b1;
            end
         end
         ST_DRAIN: begin
            active   = 1'b1;
            imem_req = 1'b1;
            if (redirect) begin
               redir_hit = 1'b1;
            end else if (halt) begin
               state_d = ST_HALTED;
            end else if (imem_ready) begin
               state_d = ST_FETCH;
            end
         end
         ST_HALTED: halted = 1'b1;
         default:   state_d = ST_RESET;
      endcase

      if (redir_hit) begin
         PCSrc       = jalr_ex ? 2'b10 : 2'b01;
         pc_en       = 1'b1;
         flush_if_id = 1'b1;
         flush_id_ex = 1'b1;
      end

      if (rst) begin
         state_d     = ST_RESET;
         imem_req    = 1'b0;
         PCSrc       = 2'b00;
         pc_en       = 1'b0;
         fetch_valid = 1'b0;
         stall_if_id = 1'b0;
         flush_if_id = 1'b0;
         flush_id_ex = 1'b0;
         halted      = 1'b0;
         redir_hit   = 1'b0;
         active      = 1'b0;
      end

      stall_count_d = stall_count_q;
      if (active && !pc_en && stall_count_q != CNT_MAX) begin
         stall_count_d = stall_count_q + 1'b1;
      end

      redirect_count_d = redirect_count_q;
      if (redir_hit && redirect_count_q != CNT_MAX) begin
         redirect_count_d = redirect_count_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q          <= ST_RESET;
         redirect_count_q <= '0;
         stall_count_q    <= '0;
      end else begin
         state_q          <= state_d;
         redirect_count_q <= redirect_count_d;
         stall_count_q    <= stall_count_d;
      end
   end

   assign redirect_count = redirect_count_q;
   assign stall_count    = stall_count_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: directed vector table, counter saturation on a
// narrow-counter instance, and randomized traffic against a behavioural model.
module tb_fetch_controller;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, imem_ready, load_use_hazard;
   logic        branch_taken_ex, jalr_ex, halt;
   logic        imem_req, pc_en, fetch_valid;
   logic        stall_if_id, flush_if_id, flush_id_ex, halted;
   logic [1:0]  PCSrc;
   logic [15:0] redirect_count, stall_count;

   logic        s_imem_req, s_pc_en, s_fetch_valid;
   logic        s_stall_if_id, s_flush_if_id, s_flush_id_ex, s_halted;
   logic [1:0]  s_PCSrc;
   logic [3:0]  s_redirect_count, s_stall_count;

   fetch_controller #(.WIDTH(32), .CNT_WIDTH(16)) u_dut (
      .clk             (clk),
      .rst             (rst),
      .imem_req        (imem_req),
      .imem_ready      (imem_ready),
      .load_use_hazard (load_use_hazard),
      .branch_taken_ex (branch_taken_ex),
      .jalr_ex         (jalr_ex),
      .halt            (halt),
      .PCSrc           (PCSrc),
      .pc_en           (pc_en),
      .fetch_valid     (fetch_valid),
      .stall_if_id     (stall_if_id),
      .flush_if_id     (flush_if_id),
      .flush_id_ex     (flush_id_ex),
      .halted          (halted),
      .redirect_count  (redirect_count),
      .stall_count     (stall_count)
   );

   fetch_controller #(.WIDTH(32), .CNT_WIDTH(4)) u_sat (
      .clk             (clk),
      .rst             (rst),
      .imem_req        (s_imem_req),
      .imem_ready      (imem_ready),
      .load_use_hazard (load_use_hazard),
      .branch_taken_ex (branch_taken_ex),
      .jalr_ex         (jalr_ex),
      .halt            (halt),
      .PCSrc           (s_PCSrc),
      .pc_en           (s_pc_en),
      .fetch_valid     (s_fetch_valid),
      .stall_if_id     (s_stall_if_id),
      .flush_if_id     (s_flush_if_id),
      .flush_id_ex     (s_flush_id_ex),
      .halted          (s_halted),
      .redirect_count  (s_redirect_count),
      .stall_count     (s_stall_count)
   );

   // input vector {rst, load_use, branch, jalr, halt, ready}
   // output vector {req, PCSrc[1:0], pc_en, fetch_valid, stall, flush_if, flush_ex, halted}
   localparam logic [8:0] O_NONE = 9'b000000000;
   localparam logic [8:0] O_REQ  = 9'b100000000;
   localparam logic [8:0] O_TAKE = 9'b100110000;
   localparam logic [8:0] O_BR   = 9'b101100110;
   localparam logic [8:0] O_JR   = 9'b110100110;
   localparam logic [8:0] O_LU   = 9'b000001010;
   localparam logic [8:0] O_HALT = 9'b000000001;

   typedef struct {
      logic [5:0] in;
      logic [8:0] out;
      bit         chk;
      int         sc;
      int         rc;
   } vec_t;

   vec_t tbl[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   bit m_boot, m_halt, m_pend, m_stale;
   int m_sc, m_rc, m_sc4, m_rc4;

   function automatic logic [8:0] main_out();
      return {imem_req, PCSrc, pc_en, fetch_valid, stall_if_id,
              flush_if_id, flush_id_ex, halted};
   endfunction

   function automatic logic [8:0] sat_out();
      return {s_imem_req, s_PCSrc, s_pc_en, s_fetch_valid, s_stall_if_id,
              s_flush_if_id, s_flush_id_ex, s_halted};
   endfunction

   task automatic check(input string name, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic drive(input logic [5:0] v);
      @(negedge clk);
      {rst, load_use_hazard, branch_taken_ex, jalr_ex, halt, imem_ready} = v;
      #2;
   endtask

   task automatic add(input logic [5:0] i, input logic [8:0] o,
                      input bit c, input int sc, input int rc);
      vec_t t;
      t.in = i; t.out = o; t.chk = c; t.sc = sc; t.rc = rc;
      tbl.push_back(t);
   endtask

   function automatic int sat_inc(input int v, input int max);
      return (v >= max) ? max : v + 1;
   endfunction

   // Model view: boot = one idle cycle after reset; pend = request issued
   // but unanswered; stale = the pending answer belongs to a flushed path.
   task automatic model_step(input logic [5:0] v, output logic [8:0] e);
      logic r, l, b, j, h, y;
      logic req, pe, fv, st, fi, fd, hl;
      logic [1:0] sel;
      bit c_stall, c_redir;
      {r, l, b, j, h, y} = v;
      {req, pe, fv, st, fi, fd, hl} = '0;
      sel = 2'b00;
      c_stall = 0;
      c_redir = 0;
      if (r) begin
         m_boot = 1; m_halt = 0; m_pend = 0; m_stale = 0;
         m_sc = 0; m_rc = 0; m_sc4 = 0; m_rc4 = 0;
      end else if (m_boot) begin
         m_boot = 0;
      end else if (m_halt) begin
         hl = 1;
      end else begin
         if (b || j) begin
            sel = j ? 2'b10 : 2'b01;
            pe = 1; fi = 1; fd = 1; req = 1;
            c_redir = 1;
            if (!m_stale && m_pend) begin
               m_pend  = 0;
               m_stale = !y;
            end
         end else if (m_stale) begin
            req = 1;
            if (h) begin
               m_halt = 1; m_stale = 0;
            end else if (y) begin
               m_stale = 0;
            end
         end else if (h) begin
            m_halt = 1; m_pend = 0;
         end else if (l) begin
            st = 1; fd = 1;
         end else if (y) begin
            req = 1; fv = 1; pe = 1; m_pend = 0;
         end else begin
            req = 1; m_pend = 1;
         end
         c_stall = !pe;
      end
      if (c_stall) begin
         m_sc  = sat_inc(m_sc, 65535);
         m_sc4 = sat_inc(m_sc4, 15);
      end
      if (c_redir) begin
         m_rc  = sat_inc(m_rc, 65535);
         m_rc4 = sat_inc(m_rc4, 15);
      end
      e = {req, sel, pe, fv, st, fi, fd, hl};
   endtask

   initial begin
      logic [5:0] v;
      logic [8:0] e;
      {rst, load_use_hazard, branch_taken_ex, jalr_ex, halt, imem_ready} = 6'b100000;

      // reset, zero-wait stream, 2-cycle memory
      add(6'b100000, O_NONE, 0, 0, 0);
      add(6'b100000, O_NONE, 1, 0, 0);
      add(6'b100001, O_NONE, 1, 0, 0);
      add(6'b000001, O_NONE, 1, 0, 0);
      for (int k = 0; k < 8; k++) add(6'b000001, O_TAKE, 1, 0, 0);
      add(6'b000000, O_REQ,  1, 0, 0);
      add(6'b000000, O_REQ,  1, 1, 0);
      add(6'b000001, O_TAKE, 1, 2, 0);
      add(6'b000000, O_REQ,  1, 2, 0);
      add(6'b000000, O_REQ,  1, 3, 0);
      add(6'b000001, O_TAKE, 1, 4, 0);
      add(6'b000000, O_REQ,  1, 4, 0);
      add(6'b000000, O_REQ,  1, 5, 0);
      add(6'b000001, O_TAKE, 1, 6, 0);
      add(6'b000001, O_TAKE, 1, 6, 0);
      // redirects in FETCH
      add(6'b001001, O_BR,   1, 6, 0);
      add(6'b000001, O_TAKE, 1, 6, 1);
      add(6'b001101, O_JR,   1, 6, 1);
      add(6'b000001, O_TAKE, 1, 6, 2);
      add(6'b011001, O_BR,   1, 6, 2);
      add(6'b000001, O_TAKE, 1, 6, 3);
      // load-use then consume
      add(6'b010001, O_LU,   1, 6, 3);
      add(6'b000001, O_TAKE, 1, 7, 3);
      // jalr in WAIT, stale drained two cycles later
      add(6'b000000, O_REQ,  1, 7, 3);
      add(6'b000100, O_JR,   1, 8, 3);
      add(6'b000000, O_REQ,  1, 8, 4);
      add(6'b000001, O_REQ,  1, 9, 4);
      add(6'b000001, O_TAKE, 1, 10, 4);
      // halt in FETCH, inputs ignored
      add(6'b000010, O_NONE, 1, 10, 4);
      add(6'b011111, O_HALT, 1, 11, 4);
      add(6'b000001, O_HALT, 1, 11, 4);
      add(6'b100000, O_NONE, 1, 11, 4);
      // halt in WAIT
      add(6'b000000, O_NONE, 1, 0, 0);
      add(6'b000000, O_REQ,  1, 0, 0);
      add(6'b000010, O_NONE, 1, 1, 0);
      add(6'b000000, O_HALT, 1, 2, 0);
      add(6'b100000, O_NONE, 1, 2, 0);
      // WAIT load-use, WAIT redirect, DRAIN redirect and halt
      add(6'b000000, O_NONE, 1, 0, 0);
      add(6'b000000, O_REQ,  1, 0, 0);
      add(6'b010001, O_LU,   1, 1, 0);
      add(6'b001001, O_BR,   1, 2, 0);
      add(6'b000001, O_TAKE, 1, 2, 1);
      add(6'b000000, O_REQ,  1, 2, 1);
      add(6'b001000, O_BR,   1, 3, 1);
      add(6'b000100, O_JR,   1, 3, 2);
      add(6'b000010, O_REQ,  1, 3, 3);
      add(6'b000000, O_HALT, 1, 4, 3);

      foreach (tbl[i]) begin
         drive(tbl[i].in);
         check($sformatf("vec%0d_out", i), 32'(main_out()), 32'(tbl[i].out));
         if (tbl[i].chk) begin
            check($sformatf("vec%0d_cnt", i), {stall_count, redirect_count},
                  {tbl[i].sc[15:0], tbl[i].rc[15:0]});
         end
      end

      // saturation: 20 stalls and 20 redirects against a 4-bit instance
      drive(6'b100000);
      drive(6'b000000);
      for (int k = 0; k < 20; k++) drive(6'b010000);
      for (int k = 0; k < 20; k++) drive(6'b001000);
      drive(6'b100000);
      check("sat_main", {stall_count, redirect_count}, {16'd20, 16'd20});
      check("sat_narrow", 32'({s_stall_count, s_redirect_count}), 32'h0000_00ff);

      // randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         v[5] = (i == 0) || ($urandom_range(0, 99) == 0);
         v[4] = ($urandom_range(0, 4) == 0);
         v[3] = ($urandom_range(0, 5) == 0);
         v[2] = ($urandom_range(0, 7) == 0);
         v[1] = ($urandom_range(0, 199) == 0);
         v[0] = $urandom_range(0, 1) == 1;
         drive(v);
         if (i > 0) begin
            check("rnd_cnt", {stall_count, redirect_count},
                  {m_sc[15:0], m_rc[15:0]});
            check("rnd_cnt4", 32'({s_stall_count, s_redirect_count}),
                  32'({m_sc4[3:0], m_rc4[3:0]}));
         end
         model_step(v, e);
         check("rnd_out", 32'(main_out()), 32'(e));
         check("rnd_out4", 32'(sat_out()), 32'(e));
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
